// File: rtl/dsc_pkg.sv
// Shared defaults and types for the deterministic stochastic-computing multiplier.
package dsc_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_INPUTS = 2;
    localparam int DEF_OUT_W      = DEF_NUM_INPUTS * DEF_DATA_WIDTH;
    localparam int WXIP1          = DEF_OUT_W + 1;

    typedef logic [DEF_DATA_WIDTH-1:0] operand_arr_t [DEF_NUM_INPUTS];

endpackage

// File: rtl/dsc_mul_core_counter.sv
// Strided wrap-around counter with a sticky carry-out flag; async active-high reset.
module dsc_mul_core_counter #(
    parameter int WIDTH  = 16,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] countval,
    output logic             overflow
);

    logic [WIDTH:0] sum_p0;

    assign sum_p0 = {1'b0, countval} + (WIDTH+1)'(STRIDE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countval <= '0;
            overflow <= 1'b0;
        end else if (en) begin
            countval <= sum_p0[WIDTH-1:0];
            overflow <= overflow | sum_p0[WIDTH];
        end
    end

endmodule

// File: rtl/dsc_mul_core.sv
// DSC multiplier: ones-count of the AND of clock-division unary streams.
// Optional macro DSC_ZERO_DETECT_EN finishes immediately when any operand is zero.
module dsc_mul_core
    import dsc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int OUT_W      = NUM_INPUTS * DATA_WIDTH
) (
    input  logic                  gclk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS],
    output logic [OUT_W-1:0]      bin_data_out,
    output logic                  op_finished
);

    logic [OUT_W-1:0]      cnt;
    logic [OUT_W-1:0]      acc;
    logic [NUM_INPUTS-1:0] stream_bits;
    logic                  prod_bit;
    logic                  cnt_ovf;
    logic                  done;
    logic                  adv;

    // Each operand compares against its own digit of the enumeration counter.
    always_comb begin
        stream_bits = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            stream_bits[i] = cnt[i*DATA_WIDTH +: DATA_WIDTH] < bin_data_in[i];
        end
    end

    assign prod_bit = &stream_bits;

`ifdef DSC_ZERO_DETECT_EN
    logic any_zero;

    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            any_zero = any_zero | (bin_data_in[i] == '0);
        end
    end

    assign done = (cnt[(NUM_INPUTS-1)*DATA_WIDTH +: DATA_WIDTH] >= bin_data_in[NUM_INPUTS-1])
                  | any_zero | cnt_ovf;
`else
    // The carry flag cannot set with stable operands; it only guards against lockup.
    assign done = (cnt[(NUM_INPUTS-1)*DATA_WIDTH +: DATA_WIDTH] >= bin_data_in[NUM_INPUTS-1])
                  | cnt_ovf;
`endif

    assign adv = en & ~done;

    dsc_mul_core_counter #(
        .WIDTH  (OUT_W),
        .STRIDE (1)
    ) u_enum_cnt (
        .clk      (gclk),
        .rst      (rst),
        .en       (adv),
        .countval (cnt),
        .overflow (cnt_ovf)
    );

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (adv) begin
            acc <= acc + OUT_W'(prod_bit);
        end
    end

    assign bin_data_out = acc;
    assign op_finished  = done;

endmodule

// File: tb/tb_dsc_mul_core.sv
// Randomized self-checking bench for dsc_mul_core (DATA_WIDTH=4, NUM_INPUTS=2).
module tb_dsc_mul_core;

    localparam int DW   = 4;
    localparam int NI   = 2;
    localparam int OW   = NI * DW;
    localparam int BASE = 1 << DW;

    logic          gclk;
    logic          rst;
    logic          en;
    logic [DW-1:0] x [NI];
    logic [OW-1:0] bin_data_out;
    logic          op_finished;

    int n_chk;
    int n_pass;
    int cur_x0;
    int cur_x1;
    int k_en;
    int t_len;

    dsc_mul_core #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI)
    ) dut (
        .gclk         (gclk),
        .rst          (rst),
        .en           (en),
        .bin_data_in  (x),
        .bin_data_out (bin_data_out),
        .op_finished  (op_finished)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (x0=%0d x1=%0d k=%0d)",
                      tag, got, exp, cur_x0, cur_x1, k_en);
    endtask

    // Ones among the first k points of the (d1, d0) grid, d0 fastest.
    function automatic int model_count(input int a0, input int a1, input int k);
        int rows;
        int rem;
        int c;
        rows = k / BASE;
        rem  = k % BASE;
        c = ((rows < a1) ? rows : a1) * a0;
        if (rows < a1) c += (rem < a0) ? rem : a0;
        return c;
    endfunction

    function automatic int model_len(input int a0, input int a1);
`ifdef DSC_ZERO_DETECT_EN
        if (a0 == 0 || a1 == 0) return 0;
`endif
        return a1 * BASE;
    endfunction

    task automatic set_ops(input int a0, input int a1);
        cur_x0 = a0;
        cur_x1 = a1;
        x[0]   = DW'(a0);
        x[1]   = DW'(a1);
        t_len  = model_len(a0, a1);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_out"}, int'(bin_data_out), model_count(cur_x0, cur_x1, k_en));
        check({tag, "_fin"}, int'(op_finished), int'(k_en >= t_len));
    endtask

    task automatic do_reset();
        @(negedge gclk);
        en  = 1'b0;
        rst = 1'b1;
        #1;
        k_en = 0;
        check("rst_out", int'(bin_data_out), 0);
        @(negedge gclk);
        rst = 1'b0;
        #1;
        check_state("post_rst");
    endtask

    task automatic step(input logic e);
        en = e;
        @(posedge gclk);
        if (e && k_en < t_len) k_en++;
        #1;
        check_state("step");
    endtask

    task automatic run_full(input string tag, input int a0, input int a1);
        set_ops(a0, a1);
        do_reset();
        for (int i = 0; i < t_len + 4; i++) step(1'b1);
        check({tag, "_product"}, int'(bin_data_out), a0 * a1);
        check({tag, "_done"}, int'(op_finished), 1);
    endtask

    initial begin
        int ra0;
        int ra1;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        en     = 1'b0;
        k_en   = 0;
        set_ops(0, 0);
        repeat (2) @(posedge gclk);

        run_full("3x5", 3, 5);
        run_full("15x15", 15, 15);
        run_full("9x0", 9, 0);
        run_full("0x7", 0, 7);

        // Pause: en low for 10 cycles after 40 enabled cycles.
        set_ops(3, 5);
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        check("pause_hold", int'(bin_data_out), model_count(3, 5, 40));
        for (int i = 0; i < 44; i++) step(1'b1);
        check("pause_product", int'(bin_data_out), 15);

        // Abort: rst mid-run clears outputs without a clock edge.
        set_ops(3, 5);
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1);
        #2;
        rst = 1'b1;
        #1;
        k_en = 0;
        check("abort_out", int'(bin_data_out), 0);
        check("abort_fin", int'(op_finished), 0);
        @(negedge gclk);
        rst = 1'b0;
        for (int i = 0; i < 84; i++) step(1'b1);
        check("abort_product", int'(bin_data_out), 15);

        // Truncated run yields a partial count, then completes.
        set_ops(6, 10);
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1);
        check("trunc32", int'(bin_data_out), 12);
        for (int i = 0; i < 132; i++) step(1'b1);
        check("trunc_product", int'(bin_data_out), 60);

        // Random operands with random enable gaps.
        for (int r = 0; r < 8; r++) begin
            ra0 = int'($urandom_range(0, BASE - 1));
            ra1 = int'($urandom_range(0, BASE - 1));
            set_ops(ra0, ra1);
            do_reset();
            for (int i = 0; i < 2 * t_len + 20 && k_en < t_len; i++)
                step(logic'($urandom_range(0, 3) != 0));
            for (int i = 0; i < 4; i++) step(1'b1);
            check("rand_product", int'(bin_data_out), ra0 * ra1);
            check("rand_done", int'(op_finished), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dsc_mul_core.md
Name: dsc_mul_core

Overview:
- Deterministic stochastic-computing (DSC) multiplier core.
- Computes the exact unsigned product of NUM_INPUTS binary operands, each DATA_WIDTH bits, by counting the ones of an AND of unary bitstreams.
- Streams are generated by clock division: each operand owns one digit of a shared enumeration counter.
- Used standalone under the arch-sweep bench, next to a free-running cycle counter.
- A truncated run yields an approximate partial product.

Parameters:
- DATA_WIDTH, 8, bits per operand.
- NUM_INPUTS, 2, number of operands (>=2).
- Derived: OUT_W = NUM_INPUTS*DATA_WIDTH, the width of the product and of the enumeration counter.

Ports:
- gclk  in  1  clock; all state rises on posedge.
- rst  in  1  reset.
- en  in  1  advance enable.
- bin_data_in  in  [DATA_WIDTH-1:0] x NUM_INPUTS (unpacked array)  operands x[i], unsigned.
- bin_data_out  out  OUT_W  running ones count; the exact product once finished.
- op_finished  out  1  high when the product is complete.

Interface rules:
- One clock; reset is asynchronous and active-high.
- Clock port is gclk; reset port is rst.

Behaviour:
- State:
  - cnt[OUT_W-1:0]: enumeration counter; digit d[i] = cnt[i*DATA_WIDTH +: DATA_WIDTH]; d[0] toggles fastest.
  - acc[OUT_W-1:0]: ones accumulator; bin_data_out = acc.
- Reset (async, rst=1): cnt=0, acc=0, immediately.
- Stream bit s[i] = (d[i] < x[i]); product bit p = AND of all s[i].
- done (combinational) = (d[NUM_INPUTS-1] >= x[NUM_INPUTS-1]); op_finished = done.
- Each posedge with en=1, rst=0 and done=0:
  - acc += p.
  - cnt += 1.
- When done=1, cnt and acc hold; en is ignored.
- Completion time:
  - Finishes after x[N-1] * 2^((N-1)*DATA_WIDTH) enabled cycles, with acc = product of all x[i] exactly.
  - x[N-1] <= 2^DATA_WIDTH-1, so cnt never wraps.
- x[N-1]=0: op_finished is high right after reset, acc=0.
- en=0 mid-operation: pause; state holds and resumes on the next en=1.
- rst mid-operation: abort; state cleared; a new run starts when en returns.
- Operands:
  - Used combinationally, not latched.
  - Must be stable from the first enabled cycle until op_finished.
  - Changing them mid-run gives an undefined result but no lockup.
- Truncated run:
  - bin_data_out is valid at every cycle as a partial count <= the exact product.
  - After k enabled cycles it equals the ones count of the first k enumerated points.
- Output is registered; op_finished is a combinational function of registers and inputs.

Optional Feature:
- Macro DSC_ZERO_DETECT_EN.
- Defined: done additionally asserts when any x[i]==0, so a zero operand finishes with acc=0 in 0 cycles.
- Undefined: only the top-digit rule applies, so a zero lower operand runs the full x[N-1]*2^((N-1)W) cycles, with result still 0.

Decomposition:
- Package dsc_pkg holds:
  - DATA_WIDTH and NUM_INPUTS defaults.
  - OUT_W, and WXIP1 = OUT_W+1 (the bench cycle-counter width).
  - An operand-array typedef.
- Sub-module counter (reused by the bench):
  - Parameters: WIDTH, STRIDE.
  - Ports: clk, rst (async, active-high), en, countval[WIDTH-1:0], overflow.
  - countval += STRIDE on each enabled posedge and wraps modulo 2^WIDTH.
  - overflow is sticky-set on carry-out; both are cleared by rst.
  - The core instantiates it with WIDTH=OUT_W, STRIDE=1, en = en & ~done.

Test Plan:
- Test config DATA_WIDTH=4, NUM_INPUTS=2:
  - x0=3, x1=5 -> bin_data_out=15; op_finished rises after exactly 80 enabled cycles.
  - x0=15, x1=15 -> 225 after 240 cycles; no counter wrap.
  - x1=0, x0=9 -> op_finished high immediately after reset deasserts; output 0.
  - x0=0, x1=7 -> output 0; 0 cycles with DSC_ZERO_DETECT_EN, 112 cycles without.
- Pause and abort, with x0=3, x1=5:
  - Drop en for 10 cycles at cycle 40 -> final output still 15, after 80 enabled cycles.
  - Assert rst at cycle 40 -> outputs clear asynchronously.
- Truncation, with x0=6, x1=10: stop at cycle 32 -> output 12; exact result 60 at cycle 160.
